// File: rtl/window_valid_gen_layer1.sv
// Layer-1 sliding-window valid generator: tracks the raster position of the
// incoming pixel stream and flags every position that completes a KxK window.
module window_valid_gen_layer1 #(
    parameter int IMG_W = 224,
    parameter int IMG_H = 224,
    parameter int K     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        pixel_valid_in,
    output logic        window_valid,
    output logic [9:0]  out_row,
    output logic [9:0]  out_col,
    output logic [19:0] win_cnt,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

    localparam logic [9:0] LP_COL_MAX = 10'(IMG_W - 1);
    localparam logic [9:0] LP_ROW_MAX = 10'(IMG_H - 1);
    localparam logic [9:0] LP_KM1     = 10'(K - 1);

    state_t     r_state;
    state_t     w_next;
    logic [9:0] r_col;
    logic [9:0] r_row;

    logic w_active;
    logic w_accept;
    logic w_at_win;
    logic w_last_col;
    logic w_last_pix;
    logic w_fill_end;

    assign w_active   = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_accept   = w_active && pixel_valid_in && !abort;
    assign w_at_win   = (r_row >= LP_KM1) && (r_col >= LP_KM1);
    assign w_last_col = (r_col == LP_COL_MAX);
    assign w_last_pix = w_last_col && (r_row == LP_ROW_MAX);
    assign w_fill_end = (r_row == LP_KM1) && (r_col == LP_KM1);
    assign busy       = w_active;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_FILL;
            // a 3x3 image finishes the frame on the same pixel that ends the fill
            S_FILL: if (w_accept) begin
                if (w_last_pix)      w_next = S_DONE;
                else if (w_fill_end) w_next = S_RUN;
            end
            S_RUN:  if (w_accept && w_last_pix) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) w_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            window_valid <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            win_cnt      <= '0;
            frame_done   <= 1'b0;
        end else begin
            r_state      <= w_next;
            window_valid <= w_accept && w_at_win;
            // pulse follows the DONE cycle, so it lands one cycle after the last window
            frame_done   <= (r_state == S_DONE) && !abort;
            if (abort) begin
                r_col   <= '0;
                r_row   <= '0;
                win_cnt <= '0;
            end else if ((r_state == S_IDLE) && start) begin
                r_col   <= '0;
                r_row   <= '0;
                win_cnt <= '0;
            end else if (w_accept) begin
                if (w_at_win) begin
                    out_row <= r_row - LP_KM1;
                    out_col <= r_col - LP_KM1;
                    win_cnt <= win_cnt + 20'd1;
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= (r_row == LP_ROW_MAX) ? '0 : r_row + 10'd1;
                end else begin
                    r_col <= r_col + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_window_valid_gen_layer1.sv
// Directed bench for window_valid_gen_layer1 on a 5x4 image with a 3x3 kernel.
module tb_window_valid_gen_layer1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        pixel_valid_in;
    logic        window_valid;
    logic [9:0]  out_row;
    logic [9:0]  out_col;
    logic [19:0] win_cnt;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [9:0]  q_row[$];
    logic [9:0]  q_col[$];
    logic [19:0] q_cnt[$];
    logic        q_busy[$];
    int          q_cyc[$];
    int          acc_cyc[$];
    int          fd_n = 0;
    int          fd_cyc = 0;

    // Expected windows for a 5x4 frame: pixel index and output coordinates
    int exp_idx[6] = '{12, 13, 14, 17, 18, 19};
    int exp_row[6] = '{0, 0, 0, 1, 1, 1};
    int exp_col[6] = '{0, 1, 2, 0, 1, 2};

    window_valid_gen_layer1 #(.IMG_W(5), .IMG_H(4), .K(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pixel_valid_in(pixel_valid_in), .window_valid(window_valid),
        .out_row(out_row), .out_col(out_col), .win_cnt(win_cnt),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (window_valid) begin
            q_row.push_back(out_row);
            q_col.push_back(out_col);
            q_cnt.push_back(win_cnt);
            q_busy.push_back(busy);
            q_cyc.push_back(cyc);
        end
        if (frame_done) begin
            fd_n   = fd_n + 1;
            fd_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_mon();
        q_row.delete(); q_col.delete(); q_cnt.delete();
        q_busy.delete(); q_cyc.delete(); acc_cyc.delete();
        fd_n = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            pixel_valid_in = 1'b1;
            acc_cyc.push_back(cyc + 1);
            tick();
            pixel_valid_in = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; abort = 1'b0; pixel_valid_in = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({window_valid, out_row, out_col, win_cnt, busy, frame_done} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got wv=%b row=%0d col=%0d cnt=%0d busy=%b fd=%b, expected all 0",
                     window_valid, out_row, out_col, win_cnt, busy, frame_done);
        end
        rst = 1'b1; start = 1'b0; pixel_valid_in = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        do_start();
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_busy_after_start: busy=%b expected 1", busy);
        end
        send(20, 0);
        repeat (4) tick();
        n_checks++;
        if (q_row.size() != 6) begin
            n_errors++;
            $display("FAIL b2b_window_count: got %0d expected 6", q_row.size());
        end
        for (int i = 0; i < 6 && i < q_row.size(); i++) begin
            n_checks++;
            if (q_row[i] !== 10'(exp_row[i]) || q_col[i] !== 10'(exp_col[i]) || q_cnt[i] !== 20'(i + 1)) begin
                n_errors++;
                $display("FAIL b2b_window%0d: got (%0d,%0d) cnt=%0d expected (%0d,%0d) cnt=%0d",
                         i, q_row[i], q_col[i], q_cnt[i], exp_row[i], exp_col[i], i + 1);
            end
        end
        n_checks++;
        if (fd_n != 1 || q_cyc.size() != 6 || fd_cyc != q_cyc[5] + 1) begin
            n_errors++;
            $display("FAIL b2b_frame_done: count=%0d at cycle %0d, expected 1 pulse one cycle after last window",
                     fd_n, fd_cyc);
        end
        n_checks++;
        if (q_busy.size() != 6 || q_busy[5] !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_busy_fall: busy at last window/now not 0 (now=%b)", busy);
        end
        n_checks++;
        if (win_cnt !== 20'd6) begin
            n_errors++;
            $display("FAIL b2b_win_cnt_hold: got %0d expected 6", win_cnt);
        end
    endtask

    task automatic test_gaps();
        clear_mon();
        do_start();
        send(20, 1);
        repeat (4) tick();
        n_checks++;
        if (q_row.size() != 6) begin
            n_errors++;
            $display("FAIL gap_window_count: got %0d expected 6", q_row.size());
        end
        for (int i = 0; i < 6 && i < q_row.size(); i++) begin
            n_checks++;
            if (q_row[i] !== 10'(exp_row[i]) || q_col[i] !== 10'(exp_col[i]) ||
                q_cyc[i] != acc_cyc[exp_idx[i]]) begin
                n_errors++;
                $display("FAIL gap_window%0d: got (%0d,%0d) at cycle %0d expected (%0d,%0d) at cycle %0d",
                         i, q_row[i], q_col[i], q_cyc[i], exp_row[i], exp_col[i], acc_cyc[exp_idx[i]]);
            end
        end
        n_checks++;
        if (fd_n != 1 || win_cnt !== 20'd6) begin
            n_errors++;
            $display("FAIL gap_done: frame_done=%0d win_cnt=%0d expected 1 and 6", fd_n, win_cnt);
        end
    endtask

    task automatic test_abort();
        clear_mon();
        do_start();
        send(13, 0);
        abort = 1'b1; start = 1'b1; pixel_valid_in = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; pixel_valid_in = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || window_valid !== 1'b0 || win_cnt !== 20'd0) begin
            n_errors++;
            $display("FAIL abort_clear: busy=%b wv=%b cnt=%0d expected 0 0 0", busy, window_valid, win_cnt);
        end
        pixel_valid_in = 1'b1;
        tick();
        pixel_valid_in = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 1'b0 || fd_n != 0 || q_row.size() != 1) begin
            n_errors++;
            $display("FAIL abort_idle: busy=%b frame_done=%0d windows=%0d expected 0 0 1",
                     busy, fd_n, q_row.size());
        end
        clear_mon();
        do_start();
        send(20, 0);
        repeat (4) tick();
        n_checks++;
        if (q_row.size() != 6 || fd_n != 1 || win_cnt !== 20'd6) begin
            n_errors++;
            $display("FAIL abort_restart: windows=%0d frame_done=%0d cnt=%0d expected 6 1 6",
                     q_row.size(), fd_n, win_cnt);
        end else begin
            n_checks++;
            if (q_row[5] !== 10'd1 || q_col[5] !== 10'd2) begin
                n_errors++;
                $display("FAIL abort_restart_last: got (%0d,%0d) expected (1,2)", q_row[5], q_col[5]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        do_start();
        send(15, 0);
        rst = 1'b0; pixel_valid_in = 1'b1;
        tick();
        rst = 1'b1; pixel_valid_in = 1'b0;
        n_checks++;
        if ({window_valid, out_row, out_col, win_cnt, busy, frame_done} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got wv=%b row=%0d col=%0d cnt=%0d busy=%b fd=%b, expected all 0",
                     window_valid, out_row, out_col, win_cnt, busy, frame_done);
        end
        tick();
        clear_mon();
        send(20, 0);
        repeat (3) tick();
        n_checks++;
        if (q_row.size() != 0 || fd_n != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_no_start: windows=%0d frame_done=%0d busy=%b expected 0 0 0",
                     q_row.size(), fd_n, busy);
        end
    endtask

    task automatic test_start_ignored();
        clear_mon();
        do_start();
        for (int i = 0; i < 20; i++) begin
            pixel_valid_in = 1'b1;
            start = (i == 7);
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
        pixel_valid_in = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (q_row.size() != 6 || fd_n != 1) begin
            n_errors++;
            $display("FAIL restart_ignored: windows=%0d frame_done=%0d expected 6 1", q_row.size(), fd_n);
        end
        n_checks++;
        if (win_cnt !== 20'd6 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_final: cnt=%0d busy=%b expected 6 0", win_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        repeat (2) tick();
        test_gaps();
        repeat (2) tick();
        test_abort();
        repeat (2) tick();
        test_reset_mid();
        repeat (2) tick();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/window_valid_gen_layer1.md
WINDOW_VALID_GEN_LAYER1 -- requirements
Module: window_valid_gen_layer1

Interface
REQ-001 Parameter IMG_W, default 224, input feature-map width in pixels (valid range 3..1024).
REQ-002 Parameter IMG_H, default 224, input feature-map height in pixels (valid range 3..1024).
REQ-003 Parameter K, default 3, convolution kernel size (fixed to 3 for layer 1).
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  synchronous reset, active-low, sampled on rising clk.
REQ-006 start  input  1  one-cycle frame-start request.
REQ-007 abort  input  1  synchronous frame abort.
REQ-008 pixel_valid_in  input  1  one pixel of the raster-order input stream accepted this cycle.
REQ-009 window_valid  output  1  registered; a full KxK window is available; drives the layer-1 bias/valid pipeline input.
REQ-010 out_row  output  10  registered output-window row index, meaningful when window_valid=1.
REQ-011 out_col  output  10  registered output-window column index, meaningful when window_valid=1.
REQ-012 win_cnt  output  20  windows emitted in current frame.
REQ-013 busy  output  1  high in FILL or RUN.
REQ-014 frame_done  output  1  one-cycle pulse on frame completion.

Function
REQ-015 States SHALL be IDLE, FILL, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 -> FILL, clearing col/row counters and win_cnt; pixel_valid_in ignored.
REQ-017 Internal col counter SHALL increment on each pixel_valid_in in FILL/RUN, wrap IMG_W-1 -> 0 and then increment row counter.
REQ-018 Counters SHALL hold when pixel_valid_in=0; gaps of any length are legal.
REQ-019 FILL -> RUN on the accepted pixel at (row=K-1, col=K-1).
REQ-020 window_valid SHALL be 1 exactly the cycle after an accepted pixel with row>=K-1 and col>=K-1, else 0 (latency 1, no bubbles inserted).
REQ-021 With that pulse, out_row=row-(K-1), out_col=col-(K-1) of that pixel; otherwise both hold their last value.
REQ-022 win_cnt SHALL increment by 1 in the same cycle window_valid rises/pulses; final value (IMG_W-K+1)*(IMG_H-K+1).
REQ-023 Accepted pixel at (IMG_H-1, IMG_W-1) -> DONE; its window_valid still issues.
REQ-024 DONE lasts one cycle with frame_done=1, then IDLE; win_cnt holds until next start.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 abort=1 in any state -> IDLE next cycle, window_valid=0, no frame_done, counters cleared; abort overrides simultaneous start and pixel_valid_in.
REQ-027 pixel_valid_in in DONE SHALL be ignored (no counting, no window).
REQ-028 Counters SHALL never exceed IMG_W-1 / IMG_H-1.

Reset
REQ-029 rst=0 at a rising edge SHALL force IDLE and window_valid=0, out_row=0, out_col=0, win_cnt=0, busy=0, frame_done=0, counters 0, regardless of other inputs.
REQ-030 Reset mid-frame SHALL discard the frame; first cycle after release is IDLE with no pulse on any output.

Verification (IMG_W=5, IMG_H=4, K=3)
REQ-031 start, then 20 back-to-back pixels -> 6 window_valid pulses, (out_row,out_col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); win_cnt=6; frame_done one cycle after last window_valid; busy falls with DONE.
REQ-032 Same frame with pixel_valid_in toggling 1/0 every cycle -> identical 6 windows/coordinates, each window_valid exactly one cycle after its pixel.
REQ-033 abort asserted after 13th pixel -> IDLE next cycle, win_cnt=0, no frame_done; new start + 20 pixels -> normal 6 windows.
REQ-034 rst=0 for one cycle after 15th pixel -> all outputs 0 next cycle; subsequent pixels without start produce no window_valid.
REQ-035 start pulsed again at pixel 8 and pixel_valid_in held high in DONE -> ignored; exactly 6 windows, single frame_done.
